mem_arbiter: RTL and testbench

Two-requester arbiter placing the core's instruction-fetch and load/store paths on the single memory port driven into `memctl`. It latches one request at a time, forwards it on the shared `mem_*` handshake, returns the response to the owning requester, and alternates ownership round-robin on contention. A watchdog counter ends any transaction that memory never acknowledges and flags a bus error.

---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: fetch and load/store share one registered memory port.
// Round-robin on contention, with a watchdog that force-completes a silent transaction and flags bus_error.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_read_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_read_data,
    output logic              if_ready,

    input  logic              d_read_valid,
    input  logic              d_write_valid,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_width,
    input  logic [DATA_W-1:0] d_write_data,
    output logic [DATA_W-1:0] d_read_data,
    output logic              d_ready,

    output logic              mem_read_valid,
    output logic              mem_write_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_width,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_ready,

    output logic              bus_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;   // 1: data path owned the most recent grant
    logic [7:0]        wdog_q, wdog_d;
    logic              mem_rv_q, mem_rv_d;
    logic              mem_wv_q, mem_wv_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]        mem_width_q, mem_width_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic if_req, d_req, grant_i, grant_d;
    logic busy, timeout_hit, done;

    assign if_req  = if_read_valid;
    assign d_req   = d_read_valid | d_write_valid;
    // Fetch wins a tie only when data held the previous grant.
    assign grant_i = if_req & (~d_req | last_d_q);
    assign grant_d = d_req & ~grant_i;

    // Watchdog holds (busy cycle - 1), so the compare lands on busy cycle TIMEOUT.
    assign busy        = (state_q != IDLE);
    assign timeout_hit = busy & (wdog_q == WDOG_LAST);
    assign done        = busy & (mem_ready | timeout_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            wdog_q      <= 8'd0;
            mem_rv_q    <= 1'b0;
            mem_wv_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_width_q <= 2'b00;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            wdog_q      <= wdog_d;
            mem_rv_q    <= mem_rv_d;
            mem_wv_q    <= mem_wv_d;
            mem_addr_q  <= mem_addr_d;
            mem_width_q <= mem_width_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        wdog_d      = wdog_q;
        mem_rv_d    = mem_rv_q;
        mem_wv_d    = mem_wv_q;
        mem_addr_d  = mem_addr_q;
        mem_width_d = mem_width_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d     = BUSY_I;
                    last_d_d    = 1'b0;
                    wdog_d      = 8'd0;
                    mem_rv_d    = 1'b1;
                    mem_wv_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_width_d = WIDTH_WORD;
                end else if (grant_d) begin
                    state_d     = BUSY_D;
                    last_d_d    = 1'b1;
                    wdog_d      = 8'd0;
                    // A simultaneous read+write request is taken as a write.
                    mem_rv_d    = ~d_write_valid;
                    mem_wv_d    = d_write_valid;
                    mem_addr_d  = d_addr;
                    mem_width_d = d_width;
                    mem_wdata_d = d_write_data;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    state_d  = IDLE;
                    mem_rv_d = 1'b0;
                    mem_wv_d = 1'b0;
                end else if (wdog_q != 8'hFF) begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                mem_rv_d = 1'b0;
                mem_wv_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        if_ready     = 1'b0;
        d_ready      = 1'b0;
        if_read_data = '0;
        d_read_data  = '0;
        bus_error    = 1'b0;

        if (state_q == BUSY_I) begin
            if_ready = done;
            if (mem_ready) begin
                if_read_data = mem_read_data;
            end
        end
        if (state_q == BUSY_D) begin
            d_ready = done;
            if (mem_ready) begin
                d_read_data = mem_read_data;
            end
        end
        // A late mem_ready on the timeout cycle still counts as a clean completion.
        bus_error = timeout_hit & ~mem_ready;
    end

    assign mem_read_valid  = mem_rv_q;
    assign mem_write_valid = mem_wv_q;
    assign mem_addr        = mem_addr_q;
    assign mem_width       = mem_width_q;
    assign mem_write_data  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): fetch, store, contention, timeout, reset, dropped request.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_read_valid;
    logic [31:0] if_addr;
    logic [31:0] if_read_data;
    logic        if_ready;
    logic        d_read_valid;
    logic        d_write_valid;
    logic [31:0] d_addr;
    logic [1:0]  d_width;
    logic [31:0] d_write_data;
    logic [31:0] d_read_data;
    logic        d_ready;
    logic        mem_read_valid;
    logic        mem_write_valid;
    logic [31:0] mem_addr;
    logic [1:0]  mem_width;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_ready;
    logic        bus_error;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cyc [4];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_read_valid  (if_read_valid),
        .if_addr        (if_addr),
        .if_read_data   (if_read_data),
        .if_ready       (if_ready),
        .d_read_valid   (d_read_valid),
        .d_write_valid  (d_write_valid),
        .d_addr         (d_addr),
        .d_width        (d_width),
        .d_write_data   (d_write_data),
        .d_read_data    (d_read_data),
        .d_ready        (d_ready),
        .mem_read_valid (mem_read_valid),
        .mem_write_valid(mem_write_valid),
        .mem_addr       (mem_addr),
        .mem_width      (mem_width),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready),
        .bus_error      (bus_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if_read_valid = 1'b0; if_addr = 32'h0;
        d_read_valid = 1'b0; d_write_valid = 1'b0; d_addr = 32'h0;
        d_width = 2'b00; d_write_data = 32'h0;
        mem_read_data = 32'h0; mem_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_mem_rv", {31'd0, mem_read_valid}, 32'd0);
        check("rst_mem_wv", {31'd0, mem_write_valid}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_width", {30'd0, mem_width}, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        check("rst_readies", {29'd0, if_ready, d_ready, bus_error}, 32'd0);
        check("rst_rdata", if_read_data | d_read_data, 32'd0);
        rst = 1'b0;

        // Fetch only, mem_ready on busy cycle 3
        if_read_valid = 1'b1; if_addr = 32'h20;
        tick();
        check("if_mem_rv", {31'd0, mem_read_valid}, 32'd1);
        check("if_mem_wv", {31'd0, mem_write_valid}, 32'd0);
        check("if_mem_addr", mem_addr, 32'h20);
        check("if_mem_width", {30'd0, mem_width}, 32'd2);
        check("if_ready_early", {31'd0, if_ready}, 32'd0);
        tick();
        tick();
        mem_ready = 1'b1; mem_read_data = 32'h13;
        #1;
        check("if_ready", {31'd0, if_ready}, 32'd1);
        check("if_rdata", if_read_data, 32'h13);
        check("if_d_ready_idle", {31'd0, d_ready}, 32'd0);
        check("if_d_rdata_zero", d_read_data, 32'd0);
        if_read_valid = 1'b0;
        tick();
        mem_ready = 1'b0;
        check("if_mem_rv_clr", {31'd0, mem_read_valid}, 32'd0);
        // mem_ready in IDLE must not produce a pulse
        mem_ready = 1'b1;
        #1;
        check("idle_ready_ignored", {30'd0, if_ready, d_ready}, 32'd0);
        mem_ready = 1'b0;

        // Store byte
        d_write_valid = 1'b1; d_addr = 32'h104; d_width = 2'b00; d_write_data = 32'hAB;
        tick();
        check("st_mem_wv", {31'd0, mem_write_valid}, 32'd1);
        check("st_mem_rv", {31'd0, mem_read_valid}, 32'd0);
        check("st_mem_addr", mem_addr, 32'h104);
        check("st_mem_width", {30'd0, mem_width}, 32'd0);
        check("st_mem_wdata", mem_write_data, 32'hAB);
        tick();
        mem_ready = 1'b1; mem_read_data = 32'h5555;
        #1;
        check("st_d_ready", {31'd0, d_ready}, 32'd1);
        check("st_if_ready", {31'd0, if_ready}, 32'd0);
        d_write_valid = 1'b0;
        tick();
        mem_ready = 1'b0;
        check("st_mem_wv_clr", {31'd0, mem_write_valid}, 32'd0);

        // Continuous contention, memory answers on busy cycle 2
        if_read_valid = 1'b1; if_addr = 32'h40;
        d_read_valid  = 1'b1; d_addr  = 32'h80; d_width = 2'b01;
        for (int t = 0; t < 4; t++) begin
            tick();
            check($sformatf("cont%0d_addr", t), mem_addr, (t % 2 == 0) ? 32'h40 : 32'h80);
            check($sformatf("cont%0d_width", t), {30'd0, mem_width}, (t % 2 == 0) ? 32'd2 : 32'd1);
            tick();
            mem_ready = 1'b1; mem_read_data = 32'h1000 + 32'(t);
            #1;
            check($sformatf("cont%0d_if_ready", t), {31'd0, if_ready}, (t % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("cont%0d_d_ready", t), {31'd0, d_ready}, (t % 2 == 0) ? 32'd0 : 32'd1);
            check($sformatf("cont%0d_rdata", t), if_read_data | d_read_data, 32'h1000 + 32'(t));
            done_cyc[t] = cyc;
            if (t == 3) begin
                if_read_valid = 1'b0;
                d_read_valid  = 1'b0;
            end
            tick();
            mem_ready = 1'b0;
        end
        check("cont_pair_cycles", 32'(done_cyc[2] - done_cyc[0]), 32'd6);

        // Timeout: fetch granted (data held last grant), data request pending
        if_read_valid = 1'b1; if_addr = 32'h60;
        d_read_valid  = 1'b1; d_addr  = 32'h200; d_width = 2'b10;
        mem_read_data = 32'hDEAD;
        tick();
        check("to_grant_fetch", mem_addr, 32'h60);
        for (int b = 1; b <= 3; b++) begin
            check($sformatf("to_busy%0d_quiet", b), {30'd0, if_ready, bus_error}, 32'd0);
            tick();
        end
        check("to_if_ready", {31'd0, if_ready}, 32'd1);
        check("to_if_rdata", if_read_data, 32'd0);
        check("to_bus_error", {31'd0, bus_error}, 32'd1);
        if_read_valid = 1'b0;
        tick();
        check("to_idle_rv", {31'd0, mem_read_valid}, 32'd0);
        check("to_idle_berr", {31'd0, bus_error}, 32'd0);
        tick();
        check("to_d_grant_rv", {31'd0, mem_read_valid}, 32'd1);
        check("to_d_grant_addr", mem_addr, 32'h200);
        mem_ready = 1'b1; mem_read_data = 32'h77;
        #1;
        check("to_d_ready", {31'd0, d_ready}, 32'd1);
        d_read_valid = 1'b0;
        tick();
        mem_ready = 1'b0;

        // mem_ready exactly on the timeout cycle is a normal completion
        if_read_valid = 1'b1; if_addr = 32'h64;
        tick();
        tick(); tick(); tick();
        mem_ready = 1'b1; mem_read_data = 32'hCAFE;
        #1;
        check("tor_if_ready", {31'd0, if_ready}, 32'd1);
        check("tor_if_rdata", if_read_data, 32'hCAFE);
        check("tor_bus_error", {31'd0, bus_error}, 32'd0);
        if_read_valid = 1'b0;
        tick();
        mem_ready = 1'b0;

        // Reset in busy cycle 2 of a load
        d_read_valid = 1'b1; d_addr = 32'h300;
        tick();
        check("rs_mem_rv", {31'd0, mem_read_valid}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("rs_async_rv", {31'd0, mem_read_valid}, 32'd0);
        check("rs_d_ready", {31'd0, d_ready}, 32'd0);
        mem_ready = 1'b1;
        #1;
        check("rs_no_pulse", {31'd0, d_ready}, 32'd0);
        d_read_valid = 1'b0;
        tick();
        mem_ready = 1'b0;
        rst = 1'b0;

        // Fetch completes (fetch owns last grant), reset in IDLE, then tie -> fetch
        if_read_valid = 1'b1; if_addr = 32'h44;
        tick();
        mem_ready = 1'b1;
        #1;
        if_read_valid = 1'b0;
        tick();
        mem_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_read_valid = 1'b1; if_addr = 32'h48;
        d_read_valid  = 1'b1; d_addr  = 32'h308;
        tick();
        check("rs_tie_fetch", mem_addr, 32'h48);
        mem_ready = 1'b1;
        #1;
        if_read_valid = 1'b0;
        tick();
        mem_ready = 1'b0;
        tick();
        check("rs_then_data", mem_addr, 32'h308);
        mem_ready = 1'b1;
        #1;
        d_read_valid = 1'b0;
        tick();
        mem_ready = 1'b0;

        // Data requester drops its read mid-transaction
        d_read_valid = 1'b1; d_addr = 32'h400;
        tick();
        d_read_valid = 1'b0;
        tick();
        check("drop_rv_held", {31'd0, mem_read_valid}, 32'd1);
        tick();
        check("drop_rv_held2", {31'd0, mem_read_valid}, 32'd1);
        mem_ready = 1'b1; mem_read_data = 32'h99;
        #1;
        check("drop_d_ready", {31'd0, d_ready}, 32'd1);
        check("drop_d_rdata", d_read_data, 32'h99);
        tick();
        mem_ready = 1'b0;

        // Read+write together is a write
        d_read_valid = 1'b1; d_write_valid = 1'b1; d_addr = 32'h500;
        d_width = 2'b10; d_write_data = 32'h12345678;
        tick();
        check("rw_mem_wv", {31'd0, mem_write_valid}, 32'd1);
        check("rw_mem_rv", {31'd0, mem_read_valid}, 32'd0);
        check("rw_mem_wdata", mem_write_data, 32'h12345678);
        mem_ready = 1'b1;
        #1;
        d_read_valid = 1'b0; d_write_valid = 1'b0;
        tick();
        mem_ready = 1'b0;
        check("rw_clr", {30'd0, mem_read_valid, mem_write_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
